bin2bcd_seq: RTL and testbench

Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock) that turns an unsigned binary count (e.g. metronome BPM or beat counter) into four BCD digits. It sits directly upstream of the four-digit seven-segment multiplexer and drives its units/tens/hundreds/thousands digit inputs from registered outputs. Values above 9999 saturate and are flagged.

---
 rtl/bin2bcd_pkg.sv | 29 ++
 rtl/bin2bcd_seq_if.sv | 43 ++++
 rtl/bcd_dabble_step.sv | 16 +
 rtl/bin2bcd_seq.sv | 159 +++++++++++++++
 tb/tb_bin2bcd_seq.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
// Optional build macro: BIN2BCD_BLANK_EN (leading-zero blanking of the digit outputs).
package bin2bcd_pkg;

    // Converter control states
    typedef enum logic [1:0] {
        IDLE,
        CONV,
        DONE
    } state_t;

    localparam int          BCD_DIGITS = 4;
    localparam logic [13:0] MAX_VALUE  = 14'd9999;
    localparam logic [3:0]  BLANK_CODE = 4'hF;
    localparam int          SHIFT_BITS = 16;

    // Clamp a zero-extended input value to the largest four-digit number.
    function automatic logic [SHIFT_BITS-1:0] saturate(input logic [SHIFT_BITS-1:0] value);
        logic [SHIFT_BITS-1:0] limit;
        limit = SHIFT_BITS'(MAX_VALUE);
        return (value > limit) ? limit : value;
    endfunction

    // True when a zero-extended input value lies beyond the displayable range.
    function automatic logic exceeds_max(input logic [SHIFT_BITS-1:0] value);
        return value > SHIFT_BITS'(MAX_VALUE);
    endfunction

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Request/result bundle between a value producer, the converter and the
// seven-segment multiplexer that consumes the registered digits.
interface bin2bcd_seq_if #(
    parameter int WIDTH = 14
);

    logic             i_start;
    logic [WIDTH-1:0] i_value;
    logic             o_busy;
    logic             o_valid;
    logic             o_overflow;
    logic [3:0]       o_digit;
    logic [3:0]       o_digit_ten;
    logic [3:0]       o_digit_hundred;
    logic [3:0]       o_digit_thousand;

    // Producer side: issues requests, observes results
    modport master (
        output i_start,
        output i_value,
        input  o_busy,
        input  o_valid,
        input  o_overflow,
        input  o_digit,
        input  o_digit_ten,
        input  o_digit_hundred,
        input  o_digit_thousand
    );

    // Converter side
    modport slave (
        input  i_start,
        input  i_value,
        output o_busy,
        output o_valid,
        output o_overflow,
        output o_digit,
        output o_digit_ten,
        output o_digit_hundred,
        output o_digit_thousand
    );

endinterface

// File: rtl/bcd_dabble_step.sv
// One nibble of the shift-and-add-3 correction: any BCD digit that would
// reach 10 or more after the next left shift is pre-biased by 3.
module bcd_dabble_step (
    input  logic [3:0] nibble_in,
    output logic [3:0] nibble_out
);

    // Add-3 correction for digits of 5 and above
    always_comb begin
        nibble_out = nibble_in;
        if (nibble_in >= 4'd5) begin
            nibble_out = nibble_in + 4'd3;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one shift-and-add-3 iteration per clock.
// Values above 9999 saturate to 9999 and raise the overflow flag.
// Optional build macro: BIN2BCD_BLANK_EN replaces leading zero digits
// (thousands, hundreds, tens) with the blank code; units always show a digit.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int WIDTH = 14
) (
    input  logic          i_clk,
    input  logic          i_reset,
    bin2bcd_seq_if.slave  bus
);

    localparam int                CNT_BITS  = $clog2(SHIFT_BITS);
    localparam logic [CNT_BITS-1:0] LAST_ITER = CNT_BITS'(SHIFT_BITS - 1);

    state_t                state;
    state_t                state_next;

    logic [WIDTH-1:0]      value_in;
    logic [SHIFT_BITS-1:0] value_ext;

    logic [SHIFT_BITS-1:0] shift_q;
    logic [SHIFT_BITS-1:0] scratch_q;
    logic [SHIFT_BITS-1:0] scratch_adj;
    logic [CNT_BITS-1:0]   count_q;
    logic                  overflow_pend;

    logic [3:0]            out_unit;
    logic [3:0]            out_ten;
    logic [3:0]            out_hundred;
    logic [3:0]            out_thousand;

    logic                  busy_q;
    logic                  valid_q;
    logic                  overflow_q;
    logic [3:0]            digit_q;
    logic [3:0]            digit_ten_q;
    logic [3:0]            digit_hundred_q;
    logic [3:0]            digit_thousand_q;

    assign value_in  = bus.i_value;
    assign value_ext = SHIFT_BITS'(value_in);

    // Per-nibble add-3 correction applied ahead of every shift
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_dabble
        bcd_dabble_step u_step (
            .nibble_in  (scratch_q[4*g +: 4]),
            .nibble_out (scratch_adj[4*g +: 4])
        );
    end

    // State register
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode: accept in IDLE only, 16 iterations, one result cycle
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: begin
                if (bus.i_start) begin
                    state_next = CONV;
                end
            end
            CONV: begin
                if (count_q == LAST_ITER) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Final digit presentation, optionally with leading-zero blanking
    always_comb begin
        out_unit     = scratch_q[3:0];
        out_ten      = scratch_q[7:4];
        out_hundred  = scratch_q[11:8];
        out_thousand = scratch_q[15:12];
`ifdef BIN2BCD_BLANK_EN
        if (scratch_q[15:12] == 4'd0) begin
            out_thousand = BLANK_CODE;
            if (scratch_q[11:8] == 4'd0) begin
                out_hundred = BLANK_CODE;
                if (scratch_q[7:4] == 4'd0) begin
                    out_ten = BLANK_CODE;
                end
            end
        end
`endif
    end

    // Conversion datapath: capture, iterate, and publish the result
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            shift_q          <= '0;
            scratch_q        <= '0;
            count_q          <= '0;
            overflow_pend    <= 1'b0;
            busy_q           <= 1'b0;
            valid_q          <= 1'b0;
            overflow_q       <= 1'b0;
            digit_q          <= '0;
            digit_ten_q      <= '0;
            digit_hundred_q  <= '0;
            digit_thousand_q <= '0;
        end else begin
            valid_q <= 1'b0;
            busy_q  <= (state_next != IDLE);
            unique case (state)
                IDLE: begin
                    if (bus.i_start) begin
                        shift_q       <= saturate(value_ext);
                        overflow_pend <= exceeds_max(value_ext);
                        scratch_q     <= '0;
                        count_q       <= '0;
                    end
                end
                CONV: begin
                    // Corrected scratch and the binary operand shift as one 32-bit word
                    {scratch_q, shift_q} <= {scratch_adj[SHIFT_BITS-2:0], shift_q, 1'b0};
                    count_q              <= count_q + 1'b1;
                end
                DONE: begin
                    digit_q          <= out_unit;
                    digit_ten_q      <= out_ten;
                    digit_hundred_q  <= out_hundred;
                    digit_thousand_q <= out_thousand;
                    overflow_q       <= overflow_pend;
                    valid_q          <= 1'b1;
                end
                default: begin
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy           = busy_q;
    assign bus.o_valid          = valid_q;
    assign bus.o_overflow       = overflow_q;
    assign bus.o_digit          = digit_q;
    assign bus.o_digit_ten      = digit_ten_q;
    assign bus.o_digit_hundred  = digit_hundred_q;
    assign bus.o_digit_thousand = digit_thousand_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Scoreboard bench for bin2bcd_seq: a posedge model predicts accepted
// requests and their results, a negedge monitor compares the DUT outputs.
module tb_bin2bcd_seq;

    localparam int WIDTH = 14;

    typedef struct {
        logic [3:0] th;
        logic [3:0] hu;
        logic [3:0] te;
        logic [3:0] un;
        logic       ovf;
        int         due;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    bin2bcd_seq_if #(.WIDTH(WIDTH)) bus ();

    bin2bcd_seq #(.WIDTH(WIDTH)) dut (
        .i_clk   (clk),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    exp_t shown;
    int   cyc         = 0;
    int   acc_k       = 0;
    bit   acc_valid   = 1'b0;
    int   next_accept = 0;
    int   checks      = 0;
    int   passed      = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: decimal digits by plain arithmetic
    function automatic exp_t model(input int v, input int due);
        exp_t e;
        int   sat;
        sat   = (v > 9999) ? 9999 : v;
        e.th  = 4'(sat / 1000);
        e.hu  = 4'((sat / 100) % 10);
        e.te  = 4'((sat / 10) % 10);
        e.un  = 4'(sat % 10);
        e.ovf = (v > 9999);
        e.due = due;
`ifdef BIN2BCD_BLANK_EN
        if (sat < 1000) e.th = 4'hF;
        if (sat < 100)  e.hu = 4'hF;
        if (sat < 10)   e.te = 4'hF;
`endif
        return e;
    endfunction

    function automatic logic [16:0] pack(input exp_t e);
        return {e.ovf, e.th, e.hu, e.te, e.un};
    endfunction

    function automatic exp_t zero_result();
        exp_t e;
        e.th = 4'd0; e.hu = 4'd0; e.te = 4'd0; e.un = 4'd0; e.ovf = 1'b0; e.due = 0;
        return e;
    endfunction

    initial shown = zero_result();

    // Asynchronous reset discards any pending prediction
    always @(posedge reset) begin
        exp_q.delete();
        acc_valid   = 1'b0;
        next_accept = 0;
        shown       = zero_result();
    end

    // Model: requests accepted at most once every 18 clocks, result 17 clocks later
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (reset) begin
            exp_q.delete();
            acc_valid   = 1'b0;
            next_accept = 0;
            shown       = zero_result();
        end else if (bus.i_start && cyc >= next_accept) begin
            exp_q.push_back(model(int'(bus.i_value), cyc + 17));
            acc_k       = cyc;
            acc_valid   = 1'b1;
            next_accept = cyc + 18;
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t e;
        check("busy", 32'(bus.o_busy), 32'(acc_valid && cyc >= acc_k && cyc <= acc_k + 16));
        if (bus.o_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL unexpected_valid: got o_valid=1, expected 0 (cycle %0d)", cyc);
            end else begin
                e = exp_q.pop_front();
                check("valid_latency", 32'(cyc), 32'(e.due));
                shown = e;
            end
        end else if (exp_q.size() != 0 && exp_q[0].due < cyc) begin
            checks++;
            $display("FAIL missing_valid: got no o_valid, expected one at cycle %0d", exp_q[0].due);
            void'(exp_q.pop_front());
        end
        check("digits_ovf",
              32'({bus.o_overflow, bus.o_digit_thousand, bus.o_digit_hundred,
                   bus.o_digit_ten, bus.o_digit}),
              32'(pack(shown)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int v);
        bus.i_value = WIDTH'(v);
        bus.i_start = 1'b1;
        tick(1);
        bus.i_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            tick(1);
            n++;
        end
        if (n >= 100) begin
            checks++;
            $display("FAIL drain_timeout: got %0d pending results, expected 0", exp_q.size());
        end
        tick(2);
    endtask

    initial begin
        int vals[$];
        bus.i_start = 1'b0;
        bus.i_value = '0;
        tick(3);
        check("reset_state",
              32'({bus.o_busy, bus.o_valid, bus.o_overflow, bus.o_digit_thousand,
                   bus.o_digit_hundred, bus.o_digit_ten, bus.o_digit}), 32'd0);
        reset = 1'b0;
        tick(2);

        start(0);     drain();
        start(1234);  tick(3); bus.i_value = '0; drain();
        start(9999);  drain();
        start(12000); drain();
        start(42);    drain();

        // Second request during a conversion must be ignored
        start(500); tick(4);
        bus.i_start = 1'b1; tick(1); bus.i_start = 1'b0;
        drain();

        // Reset in the middle of a conversion
        start(1234); drain();
        start(7777); tick(7);
        reset = 1'b1;
        #1;
        check("mid_reset",
              32'({bus.o_busy, bus.o_valid, bus.o_overflow, bus.o_digit_thousand,
                   bus.o_digit_hundred, bus.o_digit_ten, bus.o_digit}), 32'd0);
        tick(1);
        reset = 1'b0;
        tick(25);
        start(7777); drain();

        // Back-to-back with i_start held high: boundaries plus random values
        for (int v = 0; v <= 120; v++)      vals.push_back(v);
        for (int v = 990; v <= 1010; v++)   vals.push_back(v);
        for (int v = 9980; v <= 10020; v++) vals.push_back(v);
        for (int v = 16370; v <= 16383; v++) vals.push_back(v);
        for (int i = 0; i < 1200; i++)      vals.push_back(int'($urandom_range(0, 16383)));
        bus.i_start = 1'b1;
        foreach (vals[i]) begin
            bus.i_value = WIDTH'(vals[i]);
            tick(18);
        end
        bus.i_start = 1'b0;
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of run, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
